// File: rtl/div_arbiter.sv
// div_arbiter: shares one iterative divider between two requesters.
// Round-robin grant, operands held on the divider for the whole operation,
// completion routed back to the owner only. Handles requester abort, a
// one-cycle flush of stale divider ready, and a completion watchdog.
// TIMEOUT_CYCLES is expected to be at least 40 so a nominal divide
// (about 37 cycles) always completes before the watchdog fires.
module div_arbiter #(
  parameter int TIMEOUT_CYCLES = 48
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req0_start_i,
  input  logic [2:0]  req0_op_i,
  input  logic [31:0] req0_dividend_i,
  input  logic [31:0] req0_divisor_i,
  input  logic [4:0]  req0_waddr_i,
  output logic [31:0] req0_result_o,
  output logic        req0_ready_o,
  output logic        req0_busy_o,
  output logic [4:0]  req0_waddr_o,

  input  logic        req1_start_i,
  input  logic [2:0]  req1_op_i,
  input  logic [31:0] req1_dividend_i,
  input  logic [31:0] req1_divisor_i,
  input  logic [4:0]  req1_waddr_i,
  output logic [31:0] req1_result_o,
  output logic        req1_ready_o,
  output logic        req1_busy_o,
  output logic [4:0]  req1_waddr_o,

  output logic        div_start_o,
  output logic [2:0]  div_op_o,
  output logic [31:0] div_dividend_o,
  output logic [31:0] div_divisor_o,
  output logic [4:0]  div_waddr_o,
  input  logic [31:0] div_result_i,
  input  logic        div_ready_i,
  input  logic        div_busy_i,

  output logic        timeout_o
);

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = ($clog2(TIMEOUT_CYCLES + 1) > 6) ? $clog2(TIMEOUT_CYCLES + 1) : 6;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t             state, state_nxt;
  logic               grant, grant_nxt;
  logic               rr_ptr, rr_nxt;
  logic [CNT_W-1:0]   run_cnt, cnt_nxt;

  logic               in_run;
  logic               g_start;
  logic [2:0]         g_op;
  logic [DATA_W-1:0]  g_dividend;
  logic [DATA_W-1:0]  g_divisor;
  logic [ADDR_W-1:0]  g_waddr;
  logic               tmo_hit;
  logic               done;
  logic               tmo;
  logic               cmpl;
  logic [DATA_W-1:0]  ret_result;

  // The divider busy flag is observed only; no arbiter decision depends on it.
  logic unused_div_busy;
  assign unused_div_busy = div_busy_i;

  // Select the granted requester's request and operands.
  assign g_start    = grant ? req1_start_i    : req0_start_i;
  assign g_op       = grant ? req1_op_i       : req0_op_i;
  assign g_dividend = grant ? req1_dividend_i : req0_dividend_i;
  assign g_divisor  = grant ? req1_divisor_i  : req0_divisor_i;
  assign g_waddr    = grant ? req1_waddr_i    : req0_waddr_i;

  assign in_run  = (state == RUN);
  assign tmo_hit = in_run && (run_cnt >= CNT_W'(TIMEOUT_CYCLES));

  // A real completion beats an abort or the watchdog in the same cycle;
  // an abort beats the watchdog.
  assign done = in_run && div_ready_i;
  assign tmo  = in_run && !div_ready_i && g_start && tmo_hit;
  assign cmpl = done || tmo;

  // Start is dropped in the ready cycle so the divider never relatches.
  assign div_start_o    = in_run && g_start && !div_ready_i && !tmo_hit;
  assign div_op_o       = in_run ? g_op       : '0;
  assign div_dividend_o = in_run ? g_dividend : '0;
  assign div_divisor_o  = in_run ? g_divisor  : '0;
  assign div_waddr_o    = in_run ? g_waddr    : '0;

  // Watchdog completion returns zero in place of a result.
  assign ret_result = done ? div_result_i : '0;

  assign req0_ready_o  = cmpl && !grant;
  assign req1_ready_o  = cmpl && grant;
  assign req0_result_o = req0_ready_o ? ret_result  : '0;
  assign req1_result_o = req1_ready_o ? ret_result  : '0;
  assign req0_waddr_o  = req0_ready_o ? div_waddr_o : '0;
  assign req1_waddr_o  = req1_ready_o ? div_waddr_o : '0;
  assign req0_busy_o   = req0_start_i && !req0_ready_o;
  assign req1_busy_o   = req1_start_i && !req1_ready_o;
  assign timeout_o     = tmo;

  // State, grant, round-robin pointer and watchdog counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      grant   <= 1'b0;
      rr_ptr  <= 1'b0;
      run_cnt <= '0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      rr_ptr  <= rr_nxt;
      run_cnt <= cnt_nxt;
    end
  end

  // Next-state logic: grant in IDLE, finish/abort/watchdog in RUN, one FLUSH cycle.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    rr_nxt    = rr_ptr;
    cnt_nxt   = run_cnt;
    case (state)
      IDLE: begin
        if (req0_start_i || req1_start_i) begin
          grant_nxt = (req0_start_i && req1_start_i) ? rr_ptr : req1_start_i;
          cnt_nxt   = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (done) begin
          rr_nxt    = ~grant;
          state_nxt = IDLE;
        end else if (!g_start || tmo) begin
          rr_nxt    = ~grant;
          state_nxt = FLUSH;
        end else if (run_cnt != {CNT_W{1'b1}}) begin
          cnt_nxt = run_cnt + 1'b1;
        end
      end
      FLUSH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Testbench for div_arbiter: behavioural divider model plus per-scenario
// tasks with inline comparisons against values derived from the arbiter's
// intended behaviour.
module tb_div_arbiter;

  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_start_i = 1'b0, req1_start_i = 1'b0;
  logic [2:0]  req0_op_i = '0, req1_op_i = '0;
  logic [31:0] req0_dividend_i = '0, req0_divisor_i = '0;
  logic [31:0] req1_dividend_i = '0, req1_divisor_i = '0;
  logic [4:0]  req0_waddr_i = '0, req1_waddr_i = '0;
  logic [31:0] req0_result_o, req1_result_o;
  logic        req0_ready_o, req1_ready_o, req0_busy_o, req1_busy_o;
  logic [4:0]  req0_waddr_o, req1_waddr_o;
  logic        div_start_o;
  logic [2:0]  div_op_o;
  logic [31:0] div_dividend_o, div_divisor_o;
  logic [4:0]  div_waddr_o;
  logic [31:0] div_result_i;
  logic        div_ready_i;
  logic        div_busy_i;
  logic        timeout_o;

  int n_checks = 0;
  int n_pass   = 0;
  bit never_ready = 1'b0;

  always #5 clk = ~clk;

  div_arbiter #(.TIMEOUT_CYCLES(48)) dut (
    .clk(clk), .rst(rst),
    .req0_start_i(req0_start_i), .req0_op_i(req0_op_i),
    .req0_dividend_i(req0_dividend_i), .req0_divisor_i(req0_divisor_i),
    .req0_waddr_i(req0_waddr_i), .req0_result_o(req0_result_o),
    .req0_ready_o(req0_ready_o), .req0_busy_o(req0_busy_o), .req0_waddr_o(req0_waddr_o),
    .req1_start_i(req1_start_i), .req1_op_i(req1_op_i),
    .req1_dividend_i(req1_dividend_i), .req1_divisor_i(req1_divisor_i),
    .req1_waddr_i(req1_waddr_i), .req1_result_o(req1_result_o),
    .req1_ready_o(req1_ready_o), .req1_busy_o(req1_busy_o), .req1_waddr_o(req1_waddr_o),
    .div_start_o(div_start_o), .div_op_o(div_op_o),
    .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o),
    .div_waddr_o(div_waddr_o), .div_result_i(div_result_i),
    .div_ready_i(div_ready_i), .div_busy_i(div_busy_i),
    .timeout_o(timeout_o)
  );

  // Arithmetic meaning of each divider opcode (divide-by-zero: all ones / dividend).
  function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return (op == OP_DIV || op == OP_DIVU) ? 32'hFFFF_FFFF : a;
    case (op)
      OP_DIV:  return $signed(a) / $signed(b);
      OP_DIVU: return a / b;
      OP_REM:  return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  // Behavioural iterative divider: latches on start, answers after 37 cycles
  // (3 for a zero divisor), abandons the operation if start drops.
  logic [31:0] m_a, m_b;
  logic [2:0]  m_op;
  int          m_cnt;
  bit          m_busy;
  assign div_busy_i = m_busy;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy       <= 1'b0;
      div_ready_i  <= 1'b0;
      div_result_i <= '0;
      m_cnt        <= 0;
    end else begin
      div_ready_i  <= 1'b0;
      div_result_i <= '0;
      if (!m_busy) begin
        if (div_start_o && !div_ready_i) begin
          m_busy <= 1'b1;
          m_a    <= div_dividend_o;
          m_b    <= div_divisor_o;
          m_op   <= div_op_o;
          m_cnt  <= (div_divisor_o == 32'd0) ? 3 : 37;
        end
      end else if (!div_start_o) begin
        m_busy <= 1'b0;
      end else if (m_cnt > 1) begin
        m_cnt <= m_cnt - 1;
      end else if (!never_ready) begin
        m_busy       <= 1'b0;
        div_ready_i  <= 1'b1;
        div_result_i <= ref_div(m_op, m_a, m_b);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input bit s, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] wa);
    if (p == 0) begin
      req0_start_i = s; req0_op_i = op; req0_dividend_i = a; req0_divisor_i = b; req0_waddr_i = wa;
    end else begin
      req1_start_i = s; req1_op_i = op; req1_dividend_i = a; req1_divisor_i = b; req1_waddr_i = wa;
    end
  endtask

  // Step until any completion pulse (ready or timeout) or the cycle bound.
  task automatic wait_done(input int maxc, output int cyc, output bit seen);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < maxc) begin
      step();
      cyc++;
      if (req0_ready_o || req1_ready_o || timeout_o) seen = 1'b1;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(0, 1'b1, OP_DIVU, 32'd9, 32'd3, 5'd1);
    step();
    step();
    n_checks++; if (div_start_o !== 1'b0) $display("FAIL rst_div_start: got %b expected 0", div_start_o); else n_pass++;
    n_checks++; if ({div_op_o, div_dividend_o, div_divisor_o, div_waddr_o} !== '0) $display("FAIL rst_div_operands: got %h expected 0", {div_op_o, div_dividend_o, div_divisor_o, div_waddr_o}); else n_pass++;
    n_checks++; if ({req0_ready_o, req1_ready_o, timeout_o, req0_result_o, req1_result_o, req0_waddr_o, req1_waddr_o} !== '0) $display("FAIL rst_req_outputs: got %h expected 0", {req0_ready_o, req1_ready_o, timeout_o, req0_result_o, req1_result_o}); else n_pass++;
    n_checks++; if ({req0_busy_o, req1_busy_o} !== 2'b10) $display("FAIL rst_busy_follows_start: got %b expected 10", {req0_busy_o, req1_busy_o}); else n_pass++;
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    #1;
    n_checks++; if (req0_busy_o !== 1'b0) $display("FAIL rst_busy_drop: got %b expected 0", req0_busy_o); else n_pass++;
    rst = 1'b1;
    step();
    step();
    n_checks++; if (div_start_o !== 1'b0) $display("FAIL idle_no_start: got %b expected 0", div_start_o); else n_pass++;
  endtask

  task automatic test_single_divu();
    int cyc; bit seen; bit p1_bad;
    drive(0, 1'b1, OP_DIVU, 32'd100, 32'd7, 5'd5);
    #1;
    n_checks++; if (div_start_o !== 1'b0) $display("FAIL single_no_early_start: got %b expected 0", div_start_o); else n_pass++;
    step();
    n_checks++; if ({div_start_o, div_op_o, div_dividend_o, div_divisor_o, div_waddr_o} !== {1'b1, OP_DIVU, 32'd100, 32'd7, 5'd5})
      $display("FAIL single_grant: got %h expected %h", {div_start_o, div_op_o, div_dividend_o, div_divisor_o, div_waddr_o}, {1'b1, OP_DIVU, 32'd100, 32'd7, 5'd5}); else n_pass++;
    p1_bad = 1'b0;
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 60) begin
      step();
      cyc++;
      if (req1_ready_o || req1_result_o != 0 || req1_waddr_o != 0 || req1_busy_o) p1_bad = 1'b1;
      if (req0_ready_o || req1_ready_o || timeout_o) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b1) $display("FAIL single_completes: got %b expected 1", seen); else n_pass++;
    n_checks++; if ({req0_ready_o, req0_result_o, req0_waddr_o} !== {1'b1, 32'd14, 5'd5}) $display("FAIL single_result: got %h expected %h", {req0_ready_o, req0_result_o, req0_waddr_o}, {1'b1, 32'd14, 5'd5}); else n_pass++;
    n_checks++; if ({req0_busy_o, div_start_o, timeout_o} !== 3'b000) $display("FAIL single_ready_cycle_ctl: got %b expected 000", {req0_busy_o, div_start_o, timeout_o}); else n_pass++;
    n_checks++; if (p1_bad !== 1'b0) $display("FAIL single_port1_quiet: got %b expected 0", p1_bad); else n_pass++;
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    step();
    n_checks++; if ({req0_ready_o, req0_result_o} !== 33'd0) $display("FAIL single_pulse_width: got %h expected 0", {req0_ready_o, req0_result_o}); else n_pass++;
  endtask

  task automatic test_both_same_cycle();
    int cyc; bit seen;
    pulse_reset();
    drive(0, 1'b1, OP_DIV,  32'hFFFF_FFEC, 32'd3, 5'd10);
    drive(1, 1'b1, OP_REMU, 32'd17,        32'd5, 5'd11);
    step();
    n_checks++; if ({div_start_o, div_dividend_o} !== {1'b1, 32'hFFFF_FFEC}) $display("FAIL both_first_grant: got %h expected %h", {div_start_o, div_dividend_o}, {1'b1, 32'hFFFF_FFEC}); else n_pass++;
    wait_done(60, cyc, seen);
    n_checks++; if ({seen, req0_ready_o, req1_ready_o, req0_result_o, req0_waddr_o} !== {3'b110, 32'hFFFF_FFFA, 5'd10})
      $display("FAIL both_port0_result: got %h expected %h", {seen, req0_ready_o, req1_ready_o, req0_result_o, req0_waddr_o}, {3'b110, 32'hFFFF_FFFA, 5'd10}); else n_pass++;
    n_checks++; if ({req1_busy_o, req1_result_o} !== {1'b1, 32'd0}) $display("FAIL both_port1_waiting: got %h expected %h", {req1_busy_o, req1_result_o}, {1'b1, 32'd0}); else n_pass++;
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    step();
    n_checks++; if (div_start_o !== 1'b0) $display("FAIL both_idle_gap: got %b expected 0", div_start_o); else n_pass++;
    step();
    n_checks++; if ({div_start_o, div_op_o, div_divisor_o} !== {1'b1, OP_REMU, 32'd5}) $display("FAIL both_second_grant: got %h expected %h", {div_start_o, div_op_o, div_divisor_o}, {1'b1, OP_REMU, 32'd5}); else n_pass++;
    wait_done(60, cyc, seen);
    n_checks++; if ({seen, req1_ready_o, req0_ready_o, req1_result_o, req1_waddr_o} !== {3'b110, 32'd2, 5'd11})
      $display("FAIL both_port1_result: got %h expected %h", {seen, req1_ready_o, req0_ready_o, req1_result_o, req1_waddr_o}, {3'b110, 32'd2, 5'd11}); else n_pass++;
    drive(1, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    step();
  endtask

  // Both ports request continuously with random operations; ownership must
  // alternate and each result must match the requester's own operands.
  task automatic test_alternate_random();
    logic [2:0]  rop[2];
    logic [31:0] ra[2], rb[2];
    logic [4:0]  rwa[2];
    int exp_owner, p, cyc;
    bit seen;
    logic [31:0] got_res;
    logic [4:0]  got_wa;
    for (int i = 0; i < 2; i++) begin
      rop[i] = 3'b100 | 3'($urandom_range(0, 3));
      ra[i]  = $urandom;
      rb[i]  = $urandom;
      if (rb[i] == 32'd0 || rb[i] == 32'hFFFF_FFFF) rb[i] = 32'd3;
      rwa[i] = 5'($urandom);
      drive(i, 1'b1, rop[i], ra[i], rb[i], rwa[i]);
    end
    exp_owner = 0;
    step();
    n_checks++; if ({div_start_o, div_dividend_o} !== {1'b1, ra[exp_owner]}) $display("FAIL alt_first_grant: got %h expected %h", {div_start_o, div_dividend_o}, {1'b1, ra[exp_owner]}); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      wait_done(60, cyc, seen);
      p = req1_ready_o ? 1 : 0;
      got_res = p ? req1_result_o : req0_result_o;
      got_wa  = p ? req1_waddr_o  : req0_waddr_o;
      n_checks++; if (seen !== 1'b1 || p != exp_owner || (req0_ready_o && req1_ready_o)) $display("FAIL alt_owner_%0d: got port %0d expected port %0d", k, p, exp_owner); else n_pass++;
      n_checks++; if ({got_res, got_wa} !== {ref_div(rop[p], ra[p], rb[p]), rwa[p]}) $display("FAIL alt_result_%0d: got %h expected %h", k, {got_res, got_wa}, {ref_div(rop[p], ra[p], rb[p]), rwa[p]}); else n_pass++;
      exp_owner = 1 - p;
      if (k < 5) begin
        rop[p] = 3'b100 | 3'($urandom_range(0, 3));
        ra[p]  = $urandom;
        rb[p]  = $urandom;
        if (rb[p] == 32'd0 || rb[p] == 32'hFFFF_FFFF) rb[p] = 32'd7;
        rwa[p] = 5'($urandom);
        drive(p, 1'b1, rop[p], ra[p], rb[p], rwa[p]);
      end else begin
        drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        drive(1, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
      end
      step();
      n_checks++; if ({div_start_o, req0_ready_o, req1_ready_o} !== 3'b000) $display("FAIL alt_gap_%0d: got %b expected 000", k, {div_start_o, req0_ready_o, req1_ready_o}); else n_pass++;
      if (k < 5) begin
        step();
        n_checks++; if ({div_start_o, div_dividend_o} !== {1'b1, ra[exp_owner]}) $display("FAIL alt_next_grant_%0d: got %h expected %h", k, {div_start_o, div_dividend_o}, {1'b1, ra[exp_owner]}); else n_pass++;
      end
    end
  endtask

  task automatic test_abort();
    int cyc; bit seen;
    drive(1, 1'b1, OP_DIV, 32'd1000, 32'd3, 5'd9);
    step();
    n_checks++; if ({div_start_o, div_dividend_o} !== {1'b1, 32'd1000}) $display("FAIL abort_grant_p1: got %h expected %h", {div_start_o, div_dividend_o}, {1'b1, 32'd1000}); else n_pass++;
    drive(0, 1'b1, OP_DIVU, 32'd81, 32'd9, 5'd4);
    for (int i = 0; i < 10; i++) step();
    drive(1, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    #1;
    n_checks++; if ({div_start_o, req0_ready_o, req1_ready_o, req1_busy_o, req0_busy_o} !== 5'b00001) $display("FAIL abort_cycle: got %b expected 00001", {div_start_o, req0_ready_o, req1_ready_o, req1_busy_o, req0_busy_o}); else n_pass++;
    step();
    n_checks++; if ({div_start_o, req0_ready_o, req1_ready_o, timeout_o} !== 4'b0000) $display("FAIL abort_flush: got %b expected 0000", {div_start_o, req0_ready_o, req1_ready_o, timeout_o}); else n_pass++;
    step();
    n_checks++; if (div_start_o !== 1'b0) $display("FAIL abort_idle: got %b expected 0", div_start_o); else n_pass++;
    step();
    n_checks++; if ({div_start_o, div_dividend_o} !== {1'b1, 32'd81}) $display("FAIL abort_p0_grant: got %h expected %h", {div_start_o, div_dividend_o}, {1'b1, 32'd81}); else n_pass++;
    wait_done(60, cyc, seen);
    n_checks++; if ({seen, req0_ready_o, req1_ready_o, req0_result_o, req0_waddr_o} !== {3'b110, 32'd9, 5'd4})
      $display("FAIL abort_p0_result: got %h expected %h", {seen, req0_ready_o, req1_ready_o, req0_result_o, req0_waddr_o}, {3'b110, 32'd9, 5'd4}); else n_pass++;
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    step();
  endtask

  task automatic test_timeout();
    int cyc; bit seen;
    never_ready = 1'b1;
    drive(0, 1'b1, OP_DIV, 32'd50, 32'd5, 5'd7);
    step();
    wait_done(60, cyc, seen);
    n_checks++; if (cyc != 48 || seen !== 1'b1) $display("FAIL tmo_cycle: got %0d expected 48", cyc); else n_pass++;
    n_checks++; if ({timeout_o, req0_ready_o, req0_result_o, div_start_o, req1_ready_o} !== {2'b11, 32'd0, 2'b00})
      $display("FAIL tmo_outputs: got %h expected %h", {timeout_o, req0_ready_o, req0_result_o, div_start_o, req1_ready_o}, {2'b11, 32'd0, 2'b00}); else n_pass++;
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    step();
    n_checks++; if ({timeout_o, req0_ready_o, div_start_o} !== 3'b000) $display("FAIL tmo_flush: got %b expected 000", {timeout_o, req0_ready_o, div_start_o}); else n_pass++;
    never_ready = 1'b0;
    step();
  endtask

  task automatic test_div_zero_and_reset();
    int cyc; bit seen;
    drive(0, 1'b1, OP_DIV, 32'd5, 32'd0, 5'd3);
    step();
    wait_done(60, cyc, seen);
    n_checks++; if ({seen, req0_ready_o, req0_result_o, req0_waddr_o} !== {2'b11, 32'hFFFF_FFFF, 5'd3}) $display("FAIL dz_result: got %h expected %h", {seen, req0_ready_o, req0_result_o, req0_waddr_o}, {2'b11, 32'hFFFF_FFFF, 5'd3}); else n_pass++;
    n_checks++; if (cyc >= 10) $display("FAIL dz_fast: got %0d cycles expected under 10", cyc); else n_pass++;
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    step();
    drive(0, 1'b1, OP_DIVU, 32'd77, 32'd7, 5'd2);
    for (int i = 0; i < 6; i++) step();
    #2 rst = 1'b0;
    #1;
    n_checks++; if ({div_start_o, div_dividend_o, div_divisor_o, req0_ready_o, req0_result_o, timeout_o} !== '0)
      $display("FAIL midrun_reset_outputs: got %h expected 0", {div_start_o, div_dividend_o, div_divisor_o, req0_ready_o, req0_result_o, timeout_o}); else n_pass++;
    n_checks++; if (req0_busy_o !== 1'b1) $display("FAIL midrun_reset_busy: got %b expected 1", req0_busy_o); else n_pass++;
    #1 rst = 1'b1;
    step();
    n_checks++; if ({div_start_o, div_dividend_o} !== {1'b1, 32'd77}) $display("FAIL post_reset_grant: got %h expected %h", {div_start_o, div_dividend_o}, {1'b1, 32'd77}); else n_pass++;
    wait_done(60, cyc, seen);
    n_checks++; if ({seen, req0_ready_o, req0_result_o} !== {2'b11, 32'd11}) $display("FAIL post_reset_result: got %h expected %h", {seen, req0_ready_o, req0_result_o}, {2'b11, 32'd11}); else n_pass++;
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    step();
  endtask

  initial begin
    test_reset();
    test_single_divu();
    test_both_same_cycle();
    test_alternate_random();
    test_abort();
    test_timeout();
    test_div_zero_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
